// File: rtl/alu_operand_regs.sv
// alu_operand_regs: operand registers A/B for the SAP-1 ALU plus the
// three-state ALU cycle (IDLE -> EXEC -> DONE). During EXEC the ALU drives
// the shared bus and the result is captured back into A with Z/N (and
// optionally C) flags.
// Optional feature macro: CARRY_FLAG_EN (carry/borrow flag logic).
module alu_operand_regs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             op_req,
    input  logic [1:0]       op_code,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [1:0]       op_select,
    output logic             alu_out,
    output logic             busy,
    output logic             done,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [1:0]       op_select_q, op_select_d;
    logic             alu_out_q, alu_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_c_q, flag_c_d;
    logic             bus_err_q, bus_err_d;
    logic             any_req_c;
    logic             carry_c;

    assign any_req_c = load_a | load_b | op_req;

`ifdef CARRY_FLAG_EN
    logic [WIDTH-1:0] sum_c;
    assign sum_c = reg_a_q + reg_b_q;

    // Carry-out of the add (wrapped sum below an operand) or borrow of the sub.
    always_comb begin
        carry_c = 1'b0;
        case (op_select_q)
            2'b00:   carry_c = (sum_c < reg_a_q);
            2'b01:   carry_c = (reg_a_q < reg_b_q);
            default: carry_c = 1'b0;
        endcase
    end
`else
    assign carry_c = 1'b0;
`endif

    // Next-state, register and flag update logic.
    always_comb begin
        state_d     = state_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        op_select_d = op_select_q;
        alu_out_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            S_IDLE: begin
                if (op_req) begin
                    // Operation wins; any simultaneous load is dropped and flagged.
                    op_select_d = op_code;
                    state_d     = S_EXEC;
                    alu_out_d   = 1'b1;
                    busy_d      = 1'b1;
                    if (load_a || load_b) begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    if (load_a) begin
                        reg_a_d = bus_in;
                    end
                    if (load_b) begin
                        reg_b_d = bus_in;
                    end
                end
            end
            S_EXEC: begin
                reg_a_d  = bus_in;
                flag_z_d = (bus_in == '0);
                flag_n_d = bus_in[WIDTH-1];
                flag_c_d = carry_c;
                state_d  = S_DONE;
                busy_d   = 1'b1;
                done_d   = 1'b1;
                if (any_req_c) begin
                    bus_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (any_req_c) begin
                    bus_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            op_select_q <= 2'b00;
            alu_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            op_select_q <= op_select_d;
            alu_out_q   <= alu_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign op_select = op_select_q;
    assign alu_out   = alu_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign bus_err   = bus_err_q;

endmodule
